// File: rtl/cube_pkg.sv
// Shared cube move definitions: face codes, the stored move record,
// the rotation inverse helper and the sequencer state encoding.
// The UNWIND state only exists when CUBE_UNDO_ALL_EN is defined.
package cube_pkg;

    localparam int FACE_W = 6;
    localparam int ROT_W  = 2;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_R = 3'd1;
    localparam logic [2:0] FACE_L = 3'd2;
    localparam logic [2:0] FACE_B = 3'd3;
    localparam logic [2:0] FACE_F = 3'd4;
    localparam logic [2:0] FACE_D = 3'd5;

    // One recorded move: only legal faces are ever stored, so 3 bits suffice
    typedef struct packed {
        logic [2:0]       face;
        logic [ROT_W-1:0] rot;
    } move_t;

`ifdef CUBE_UNDO_ALL_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_UNWIND = 1'b1} seq_state_t;
`else
    typedef enum logic {ST_IDLE = 1'b0} seq_state_t;
`endif

    // Quarter turns that cancel rot: (4 - rot) mod 4, i.e. 1<->3, 2<->2
    function automatic logic [ROT_W-1:0] inv_rot(input logic [ROT_W-1:0] rot);
        return 2'd0 - rot;
    endfunction

endpackage

// File: rtl/move_undo_sequencer_if.sv
// Handshake and status bundle between a move source and move_undo_sequencer.
// The undo_all_req wire only exists when CUBE_UNDO_ALL_EN is defined.
interface move_undo_sequencer_if #(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
);
    import cube_pkg::*;

    logic                  move_valid;
    logic                  move_ready;
    logic [FACE_W-1:0]     move_face;
    logic [ROT_W-1:0]      move_rot;
    logic                  undo_req;
`ifdef CUBE_UNDO_ALL_EN
    logic                  undo_all_req;
`endif
    logic                  out_valid;
    logic [FACE_W-1:0]     out_face;
    logic [ROT_W-1:0]      out_rot;
    logic [PTR_W:0]        depth;
    logic                  full;
    logic                  empty;
    logic                  undo_err;
    logic                  busy;

    modport master (
        output move_valid, move_face, move_rot, undo_req,
`ifdef CUBE_UNDO_ALL_EN
        output undo_all_req,
`endif
        input  move_ready, out_valid, out_face, out_rot, depth,
        input  full, empty, undo_err, busy
    );

    modport slave (
        input  move_valid, move_face, move_rot, undo_req,
`ifdef CUBE_UNDO_ALL_EN
        input  undo_all_req,
`endif
        output move_ready, out_valid, out_face, out_rot, depth,
        output full, empty, undo_err, busy
    );

endinterface

// File: rtl/move_history_stack.sv
// LIFO of recorded moves. Only the occupancy counter is reset; the
// storage array keeps whatever it held, since it is only read below count.
module move_history_stack
    import cube_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  move_t          push_data,
    output move_t          top_data,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] IDX_ONE = 1;

    move_t            mem [DEPTH];
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_idx, top_idx;

    assign wr_idx   = count_q[PTR_W-1:0];
    assign top_idx  = wr_idx - IDX_ONE;
    assign top_data = mem[top_idx];
    assign count    = count_q;

    // Next occupancy: the controller never pushes and pops in one cycle
    always_comb begin
        count_d = count_q;
        if (push) begin
            count_d = count_q + CNT_ONE;
        end else if (pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage write at the slot just above the current top
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/move_undo_sequencer.sv
// Reversible move front-end for the cube applier: records forward moves on a
// LIFO and emits either the move itself or the inverse of the latest one.
// Defining CUBE_UNDO_ALL_EN adds undo_all_req and the UNWIND state.
module move_undo_sequencer
    import cube_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  reset,
    move_undo_sequencer_if.slave bus
);

    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]      CNT_ONE  = 1;
    localparam logic [FACE_W-1:0]   MAX_FACE = {3'b000, FACE_D};

    seq_state_t        state_q, state_d;
    logic              push, pop;
    move_t             push_data, top_data;
    logic [PTR_W:0]    count;
    logic              full, empty, in_idle;
    logic              fwd_fire, fwd_legal, fwd_push;
    logic              out_valid_q, out_valid_d;
    logic [FACE_W-1:0] out_face_q, out_face_d;
    logic [ROT_W-1:0]  out_rot_q, out_rot_d;
    logic              undo_err_q, undo_err_d;

    move_history_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top_data  (top_data),
        .count     (count)
    );

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_idle   = (state_q == ST_IDLE);
    assign fwd_fire  = bus.move_valid && bus.move_ready;
    assign fwd_legal = (bus.move_face <= MAX_FACE) && (bus.move_rot != '0);
    assign fwd_push  = fwd_fire && fwd_legal;
    assign push_data = '{face: bus.move_face[2:0], rot: bus.move_rot};

    assign bus.move_ready = !full && in_idle && !bus.undo_req;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_face   = out_face_q;
    assign bus.out_rot    = out_rot_q;
    assign bus.depth      = count;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.undo_err   = undo_err_q;
`ifdef CUBE_UNDO_ALL_EN
    assign bus.busy       = (state_q == ST_UNWIND);
`else
    assign bus.busy       = 1'b0;
`endif

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a forward move arriving alongside undo_all is recorded
    // first and then unwound with the rest
    always_comb begin
        state_d = state_q;
`ifdef CUBE_UNDO_ALL_EN
        case (state_q)
            ST_IDLE: begin
                if (!bus.undo_req && bus.undo_all_req && (!empty || fwd_push)) begin
                    state_d = ST_UNWIND;
                end
            end
            ST_UNWIND: begin
                if (count == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    // Stack control and next output move; single undo beats a forward move
    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        out_valid_d = 1'b0;
        out_face_d  = '0;
        out_rot_d   = '0;
        undo_err_d  = 1'b0;
        if (in_idle) begin
            if (bus.undo_req) begin
                if (empty) begin
                    undo_err_d = 1'b1;
                end else begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_face_d  = {3'b000, top_data.face};
                    out_rot_d   = inv_rot(top_data.rot);
                end
            end else begin
                if (fwd_push) begin
                    push        = 1'b1;
                    out_valid_d = 1'b1;
                    out_face_d  = bus.move_face;
                    out_rot_d   = bus.move_rot;
                end
`ifdef CUBE_UNDO_ALL_EN
                if (bus.undo_all_req && empty && !fwd_push) begin
                    undo_err_d = 1'b1;
                end
`endif
            end
        end
`ifdef CUBE_UNDO_ALL_EN
        else begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            out_face_d  = {3'b000, top_data.face};
            out_rot_d   = inv_rot(top_data.rot);
        end
`endif
    end

    // Output register feeding the applier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_face_q  <= '0;
            out_rot_q   <= '0;
            undo_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_face_q  <= out_face_d;
            out_rot_q   <= out_rot_d;
            undo_err_q  <= undo_err_d;
        end
    end

endmodule

// File: tb/tb_move_undo_sequencer.sv
// Testbench for move_undo_sequencer: vector table, hand sequences for the
// full and unwind corners (unwind part needs CUBE_UNDO_ALL_EN), and random
// traffic compared against a queue-based reference model.
module tb_move_undo_sequencer;
    import cube_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    move_undo_sequencer_if #(.DEPTH(DEPTH)) bus ();

    move_undo_sequencer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int face;
        int rot;
    } ent_t;

    typedef struct {
        bit v;
        int face;
        int rot;
        bit undo;
        bit e_ready;
        bit e_valid;
        int e_face;
        int e_rot;
        int e_depth;
        bit e_err;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t hist[$];
    bit   m_unwind;
    int   m_valid, m_face, m_rot, m_err;

    // One comparison: counts it, and reports a line on mismatch
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_stimulus(input bit v, input int f, input int r, input bit u, input bit a);
        bus.move_valid = v;
        bus.move_face  = 6'(f);
        bus.move_rot   = 2'(r);
        bus.undo_req   = u;
`ifdef CUBE_UNDO_ALL_EN
        bus.undo_all_req = a;
`else
        if (a) $display("[TB] undo_all ignored in this build");
`endif
    endtask

    // Asynchronous reset at an arbitrary point in the cycle, then release
    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        hist.delete();
        m_unwind = 1'b0;
        #3;
        check_output("rst depth", bus.depth, 0);
        check_output("rst empty", bus.empty, 1);
        check_output("rst full", bus.full, 0);
        check_output("rst out_valid", bus.out_valid, 0);
        check_output("rst out_face", bus.out_face, 0);
        check_output("rst out_rot", bus.out_rot, 0);
        check_output("rst undo_err", bus.undo_err, 0);
        check_output("rst busy", bus.busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: history as a plain queue, one cycle of behaviour
    task automatic model_cycle(input bit v, input int f, input int r, input bit u, input bit a,
                               output bit ready);
        ent_t e;
        m_valid = 0; m_face = 0; m_rot = 0; m_err = 0;
        ready = !m_unwind && (hist.size() < DEPTH) && !u;
        if (m_unwind) begin
            e = hist.pop_back();
            m_valid = 1; m_face = e.face; m_rot = (4 - e.rot) % 4;
            if (hist.size() == 0) m_unwind = 1'b0;
        end else if (u) begin
            if (hist.size() == 0) m_err = 1;
            else begin
                e = hist.pop_back();
                m_valid = 1; m_face = e.face; m_rot = (4 - e.rot) % 4;
            end
        end else begin
            if (v && ready && f <= 5 && r != 0) begin
                e.face = f; e.rot = r;
                hist.push_back(e);
                m_valid = 1; m_face = f; m_rot = r;
            end
`ifdef CUBE_UNDO_ALL_EN
            if (a) begin
                if (hist.size() == 0) m_err = 1;
                else m_unwind = 1'b1;
            end
`endif
        end
    endtask

    // One clock of stimulus, checked against the reference model
    task automatic model_step(input bit v, input int f, input int r, input bit u, input bit a);
        bit exp_ready;
        apply_stimulus(v, f, r, u, a);
        #1;
        model_cycle(v, f, r, u, a, exp_ready);
        check_output("ready", bus.move_ready, exp_ready);
        @(posedge clk);
        #1;
        check_output("out_valid", bus.out_valid, m_valid);
        check_output("out_face", bus.out_face, m_face);
        check_output("out_rot", bus.out_rot, m_rot);
        check_output("depth", bus.depth, hist.size());
        check_output("full", bus.full, hist.size() == DEPTH);
        check_output("empty", bus.empty, hist.size() == 0);
        check_output("undo_err", bus.undo_err, m_err);
        check_output("busy", bus.busy, m_unwind);
    endtask

    initial begin
        vec_t vecs[16];
        int   busy_cycles;

        vecs[0]  = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        vecs[1]  = '{1, 0, 2, 0, 1, 1, 0, 2, 2, 0};
        vecs[2]  = '{1, 4, 3, 0, 1, 1, 4, 3, 3, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 1, 4, 1, 2, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 1, 0, 2, 1, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 1, 1, 3, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 5, 1, 0, 1, 1, 5, 1, 1, 0};
        vecs[9]  = '{1, 7, 1, 0, 1, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 2, 0, 0, 1, 0, 0, 0, 1, 0};
        vecs[11] = '{1, 2, 2, 0, 1, 1, 2, 2, 2, 0};
        vecs[12] = '{1, 2, 1, 1, 0, 1, 2, 2, 1, 0};
        vecs[13] = '{1, 2, 1, 0, 1, 1, 2, 1, 2, 0};
        vecs[14] = '{0, 0, 0, 1, 0, 1, 2, 3, 1, 0};
        vecs[15] = '{0, 0, 0, 1, 0, 1, 5, 3, 0, 0};

        do_reset();

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].v, vecs[i].face, vecs[i].rot, vecs[i].undo, 0);
            #1;
            check_output($sformatf("vec%0d ready", i), bus.move_ready, vecs[i].e_ready);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].e_valid);
            check_output($sformatf("vec%0d out_face", i), bus.out_face, vecs[i].e_face);
            check_output($sformatf("vec%0d out_rot", i), bus.out_rot, vecs[i].e_rot);
            check_output($sformatf("vec%0d depth", i), bus.depth, vecs[i].e_depth);
            check_output($sformatf("vec%0d undo_err", i), bus.undo_err, vecs[i].e_err);
        end

        // Fill to capacity, stall a 65th move, free one slot, then accept it
        do_reset();
        for (int i = 0; i < DEPTH; i++) model_step(1, i % 6, (i % 3) + 1, 0, 0);
        check_output("full after fill", bus.full, 1);
        for (int i = 0; i < 3; i++) model_step(1, 3, 2, 0, 0);
        check_output("stall depth", bus.depth, 64);
        check_output("stall no output", bus.out_valid, 0);
        model_step(1, 3, 2, 1, 0);
        check_output("free slot depth", bus.depth, 63);
        model_step(1, 3, 2, 0, 0);
        check_output("65th accepted face", bus.out_face, 3);
        check_output("refill depth", bus.depth, 64);

`ifdef CUBE_UNDO_ALL_EN
        // Unwind five recorded moves, in reverse order with inverse turns
        do_reset();
        model_step(1, 1, 1, 0, 0);
        model_step(1, 0, 2, 0, 0);
        model_step(1, 4, 3, 0, 0);
        model_step(1, 2, 1, 0, 0);
        model_step(1, 5, 2, 0, 0);
        model_step(0, 0, 0, 0, 1);
        busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            model_step(1, 0, 1, 1, 1);
            if (bus.busy === 1'b1) busy_cycles++;
            check_output("unwind valid", bus.out_valid, 1);
        end
        check_output("unwind busy cycles", busy_cycles, 5);
        check_output("unwind end depth", bus.depth, 0);
        model_step(0, 0, 0, 0, 1);
        check_output("unwind_all empty err", bus.undo_err, 1);

        // Reset in the middle of an unwind
        do_reset();
        for (int i = 0; i < 5; i++) model_step(1, i, 1, 0, 0);
        model_step(0, 0, 0, 0, 1);
        model_step(0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0);
        #2;
        do_reset();
        model_step(1, 5, 1, 0, 0);
`else
        busy_cycles = 0;
        check_output("busy tied low", bus.busy, busy_cycles);
`endif

        // Randomised traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int  f;
            bit  v, u, a;
            v = ($urandom_range(0, 9) < 6);
            u = ($urandom_range(0, 9) < ((i < 300) ? 1 : 3));
            a = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 63)) : int'($urandom_range(0, 5));
            model_step(v, f, int'($urandom_range(0, 3)), u, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/move_undo_sequencer.md
# move_undo_sequencer

Sequential move front-end for the cube datapath. Accepts forward face moves over a valid/ready handshake, records each on a LIFO history, and drives one registered move per cycle into the combinational move applier: the forward move itself, or the inverse of the most recent recorded move on undo. This turns the applier's one-way "state + move → new state" path into a reversible one.

## Interface
- `DEPTH`, default 64: history capacity in moves; power of two, at least 2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width, derived.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `move_valid` in 1: forward move offered.
- `move_ready` out 1: forward move accepted when high with `move_valid`.
- `move_face` in 6: face code. U=0, R=1, L=2, B=3, F=4, D=5. Values 6–63 are invalid.
- `move_rot` in 2: clockwise quarter turns, 0–3.
- `undo_req` in 1: single-cycle undo request.
- `undo_all_req` in 1: unwind-all request. Present only with `CUBE_UNDO_ALL_EN`.
- `out_valid` out 1: move for the applier this cycle.
- `out_face` out 6: applier `nextFaceMove`.
- `out_rot` out 2: applier `nextRotation`. Forced to 0 when `out_valid` is low, so the applier acts as identity.
- `depth` out PTR_W+1: number of stored moves.
- `full` out 1: `depth == DEPTH`.
- `empty` out 1: `depth == 0`.
- `undo_err` out 1: one-cycle pulse on an undo request while the history is empty.
- `busy` out 1: high while unwinding.

## Operation
- Reset values:
  - `depth=0`, `empty=1`, `full=0`.
  - `out_valid=0`, `out_face=0`, `out_rot=0`.
  - `undo_err=0`, `busy=0`, state IDLE.
  - History RAM contents are not reset.
- `move_ready = !full && state==IDLE && !undo_req`. Undo has priority over a forward move in the same cycle; the forward move stalls and is not lost.
- Forward accept:
  - Face ≤5 and rot ≠0: push {face[2:0], rot}, increment `depth`, emit the same move.
  - Face >5 or rot =0: the move is accepted and dropped. No push, no output.
- Undo in IDLE, not empty:
  - Pop the top entry and decrement `depth`.
  - Emit the same face with `out_rot = (4 - rot) mod 4`, giving 1↔3 and 2↔2.
- Undo while empty: no pop, no output; `undo_err` pulses.
- States:
  - IDLE.
  - UNWIND, exists only with the macro.
  - IDLE→UNWIND on `undo_all_req` while not empty.
  - UNWIND pops and emits one inverse per cycle.
  - UNWIND→IDLE on the cycle the last entry pops (`depth` reaches 0).
- In UNWIND, `undo_req`, `undo_all_req` and forward moves are ignored or stalled.
- `undo_all_req` while empty: `undo_err` pulses, state stays IDLE.
- Full: `move_ready` stays low until an undo frees a slot. No overwrite of the oldest entry.
- A reset asserted mid-UNWIND or mid-handshake clears everything to the reset values immediately.

## Timing
- All outputs are registered.
- Accepted move at edge N: `out_valid`/`out_face`/`out_rot` are valid for exactly one cycle after edge N. `depth` updates at edge N.
- Undo sampled at edge N: inverse output one cycle after edge N, `depth` decremented at edge N.
- Back-to-back operation: one push or pop per cycle with no bubbles.
- Unwinding d entries: `busy` is high for d cycles, with d consecutive `out_valid` cycles in reverse order of recording.
- `out_valid` never asserts in two consecutive cycles for the same entry.

## Configuration
- `CUBE_UNDO_ALL_EN` defined:
  - `undo_all_req` port, UNWIND state and `busy` exist.
- Not defined:
  - Port absent.
  - `busy` tied to 0.
  - Single-state controller; only single-step undo.

## Structure
- Shared package `cube_pkg`:
  - Face code constants `FACE_U..FACE_D`.
  - `move_t` struct {face[2:0], rot[1:0]}.
  - `inv_rot()` function.
  - `FACE_W=6`, `ROT_W=2`.
- Sub-module `move_history_stack`: LIFO of `DEPTH` × 5 bits, push/pop, top read, count. Pointer logic only is reset.
- Top level holds the controller, the output register and inverse generation.

## Test plan
- Reset, then push R/1, U/2, F/3 → outputs (1,1), (0,2), (4,3) on consecutive cycles; `depth` =3.
- Three `undo_req` pulses → outputs (4,1), (0,2), (1,3); `depth` =0; `empty` =1.
- `undo_req` with empty history → `undo_err` pulses once, `out_valid` stays 0; a following forward move D/1 proceeds normally.
- Fill with 64 moves → `full` =1 and `move_ready` =0. A 65th move stalls until one undo, then is accepted; `depth` returns to 64.
- `undo_req` and `move_valid` (L/1) in the same cycle with depth 2 → inverse of top emitted first; L/1 accepted on the next cycle.
- Macro on: push 5 moves, then `undo_all_req` → `busy` high 5 cycles with 5 inverse outputs in reverse order. Assert `reset` after the 2nd output → all outputs reset; `depth` =0.
